// File: rtl/interruption_controller.sv
// Interruption controller: synchronises the user request, runs the watchdog counter,
// holds pending requests and dispatches one strobe per boundary. Optional debounce: USER_DEBOUNCE_EN.
module interruption_controller #(
  parameter int unsigned         WATCHDOG_WIDTH  = 32,
  parameter logic [31:0]         WATCHDOG_PERIOD = 32'd1000000,
  parameter logic [15:0]         DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clock,
  input  logic reset,
  input  logic user_request,
  input  logic interruption_enable,
  input  logic instruction_boundary,
  input  logic interruption_return,
  input  logic watchdog_enable,
  input  logic watchdog_clear,
  output logic user_interruption,
  output logic watchdog_interruption,
  output logic in_service,
  output logic user_pending,
  output logic watchdog_pending
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    SERVICE
  } state_t;

  localparam logic [WATCHDOG_WIDTH-1:0] WD_LAST = WATCHDOG_WIDTH'(WATCHDOG_PERIOD - 32'd1);

  state_t                    state, state_next;
  logic                      sync_meta, sync_level;
  logic                      edge_prev;
  logic                      user_level;
  logic                      user_edge;
  logic [WATCHDOG_WIDTH-1:0] wd_count;
  logic                      wd_expire;
  logic                      dispatch;
  logic                      pick_user, pick_wd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= user_request;
      sync_level <= sync_meta;
    end
  end

`ifdef USER_DEBOUNCE_EN
  logic        deb_level;
  logic [15:0] deb_count;

  // Debounced level follows the synchronised level only after a full run of stable cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_level <= 1'b0;
      deb_count <= 16'd0;
    end else if (sync_level == deb_level) begin
      deb_count <= 16'd0;
    end else if (deb_count == DEBOUNCE_CYCLES - 16'd1) begin
      deb_level <= sync_level;
      deb_count <= 16'd0;
    end else begin
      deb_count <= deb_count + 16'd1;
    end
  end

  assign user_level = deb_level;
`else
  logic unused_debounce_cfg;
  assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
  assign user_level          = sync_level;
`endif

  assign user_edge = user_level & ~edge_prev;

  always_ff @(posedge clock) begin
    if (reset) edge_prev <= 1'b0;
    else       edge_prev <= user_level;
  end

  // Clear wins over counting and expiry; the counter runs regardless of FSM state.
  assign wd_expire = watchdog_enable && !watchdog_clear && (wd_count == WD_LAST);

  always_ff @(posedge clock) begin
    if (reset)                wd_count <= '0;
    else if (watchdog_clear)  wd_count <= '0;
    else if (wd_expire)       wd_count <= '0;
    else if (watchdog_enable) wd_count <= wd_count + WATCHDOG_WIDTH'(1);
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    dispatch   = 1'b0;
    case (state)
      IDLE: begin
        if (instruction_boundary && interruption_enable && (user_pending || watchdog_pending)) begin
          dispatch   = 1'b1;
          state_next = DISPATCH;
        end
      end
      DISPATCH: state_next = SERVICE;
      SERVICE:  if (interruption_return) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign pick_user = dispatch & user_pending;
  assign pick_wd   = dispatch & ~user_pending & watchdog_pending;

  // A new event in the same cycle as its dispatch keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                 <= IDLE;
      user_interruption     <= 1'b0;
      watchdog_interruption <= 1'b0;
      user_pending          <= 1'b0;
      watchdog_pending      <= 1'b0;
    end else begin
      state                 <= state_next;
      user_interruption     <= pick_user;
      watchdog_interruption <= pick_wd;
      user_pending          <= (user_pending & ~pick_user) | user_edge;
      watchdog_pending      <= (watchdog_pending & ~pick_wd) | wd_expire;
    end
  end

  assign in_service = (state != IDLE);

endmodule

// File: tb/tb_interruption_controller.sv
// Directed self-checking bench for interruption_controller (WATCHDOG_PERIOD=8, DEBOUNCE_CYCLES=4).
module tb_interruption_controller;

`ifdef USER_DEBOUNCE_EN
  localparam int USER_LAT = 7;
`else
  localparam int USER_LAT = 3;
`endif

  logic clock;
  logic reset;
  logic user_request;
  logic interruption_enable;
  logic instruction_boundary;
  logic interruption_return;
  logic watchdog_enable;
  logic watchdog_clear;
  logic user_interruption;
  logic watchdog_interruption;
  logic in_service;
  logic user_pending;
  logic watchdog_pending;

  int checks = 0;
  int errors = 0;
  int ucount;
  int wcount;

  interruption_controller #(
    .WATCHDOG_WIDTH (32),
    .WATCHDOG_PERIOD(32'd8),
    .DEBOUNCE_CYCLES(16'd4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .user_request         (user_request),
    .interruption_enable  (interruption_enable),
    .instruction_boundary (instruction_boundary),
    .interruption_return  (interruption_return),
    .watchdog_enable      (watchdog_enable),
    .watchdog_clear       (watchdog_clear),
    .user_interruption    (user_interruption),
    .watchdog_interruption(watchdog_interruption),
    .in_service           (in_service),
    .user_pending         (user_pending),
    .watchdog_pending     (watchdog_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // {user_interruption, watchdog_interruption, in_service, user_pending, watchdog_pending}
  function automatic logic [4:0] outs();
    return {user_interruption, watchdog_interruption, in_service, user_pending, watchdog_pending};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    user_request         = 1'b0;
    interruption_enable  = 1'b0;
    instruction_boundary = 1'b0;
    interruption_return  = 1'b0;
    watchdog_enable      = 1'b0;
    watchdog_clear       = 1'b0;
    reset                = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset) check("no_overlap", {31'b0, user_interruption & watchdog_interruption}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    reset = 1'b1;
    tick();
    check("reset_outs", outs(), 5'b00000);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", outs(), 5'b00000);
    end

    // Watchdog expiry and dispatch with boundary held high.
    do_reset();
    watchdog_enable      = 1'b1;
    interruption_enable  = 1'b1;
    instruction_boundary = 1'b1;
    repeat (7) tick();
    check("wd_before_expiry", outs(), 5'b00000);
    tick();
    check("wd_pending_set", outs(), 5'b00001);
    tick();
    check("wd_dispatch", outs(), 5'b01100);
    tick();
    check("wd_service", outs(), 5'b00100);
    tick();
    check("wd_hold_service", outs(), 5'b00100);
    interruption_return = 1'b1;
    tick();
    interruption_return = 1'b0;
    check("wd_return", outs(), 5'b00000);

    // User and watchdog become pending on the same edge; user wins.
    do_reset();
    watchdog_enable     = 1'b1;
    interruption_enable = 1'b1;
    repeat (8 - USER_LAT) tick();
    user_request = 1'b1;
    repeat (USER_LAT) tick();
    check("both_pending", outs(), 5'b00011);
    instruction_boundary = 1'b1;
    tick();
    instruction_boundary = 1'b0;
    check("user_first", outs(), 5'b10101);
    tick();
    check("user_service", outs(), 5'b00101);
    interruption_return  = 1'b1;
    instruction_boundary = 1'b1;
    tick();
    interruption_return = 1'b0;
    check("return_beats_boundary", outs(), 5'b00001);
    tick();
    check("wd_follows", outs(), 5'b01100);
    instruction_boundary = 1'b0;
    tick();
    check("wd_follow_service", outs(), 5'b00100);
    user_request = 1'b0;

    // Global enable low keeps a user request waiting.
    do_reset();
    instruction_boundary = 1'b1;
    user_request         = 1'b1;
    repeat (USER_LAT - 1) tick();
    check("user_latency", outs(), 5'b00000);
    tick();
    check("user_latched", outs(), 5'b00010);
    user_request = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("masked", outs(), 5'b00010);
    end
    interruption_enable = 1'b1;
    tick();
    check("unmasked_dispatch", outs(), 5'b10100);

    // Periodic kicks prevent expiry; a held user level yields one dispatch.
    do_reset();
    watchdog_enable      = 1'b1;
    interruption_enable  = 1'b1;
    instruction_boundary = 1'b1;
    interruption_return  = 1'b1;
    user_request         = 1'b1;
    ucount = 0;
    wcount = 0;
    for (int i = 0; i < 60; i++) begin
      watchdog_clear = (i % 6 == 5);
      tick();
      ucount += int'(user_interruption);
      wcount += int'(watchdog_interruption);
      check("wd_cleared", {31'b0, watchdog_pending}, 32'd0);
    end
    user_request        = 1'b0;
    watchdog_clear      = 1'b0;
    interruption_return = 1'b0;
    check("held_user_once", ucount, 32'd1);
    check("no_wd_strobe", wcount, 32'd0);

    // Reset during service drops everything.
    do_reset();
    interruption_enable = 1'b1;
    watchdog_enable     = 1'b1;
    user_request        = 1'b1;
    repeat (USER_LAT) tick();
    user_request = 1'b0;
    repeat (8 - USER_LAT) tick();
    check("pre_service", outs(), 5'b00011);
    instruction_boundary = 1'b1;
    tick();
    instruction_boundary = 1'b0;
    watchdog_enable      = 1'b0;
    tick();
    check("service_wd_pending", outs(), 5'b00101);
    reset = 1'b1;
    tick();
    check("reset_in_service", outs(), 5'b00000);
    reset = 1'b0;
    repeat (2) tick();
    check("after_reset", outs(), 5'b00000);

`ifdef USER_DEBOUNCE_EN
    do_reset();
    user_request = 1'b1;
    repeat (3) tick();
    user_request = 1'b0;
    repeat (12) tick();
    check("short_pulse", {31'b0, user_pending}, 32'd0);
    user_request = 1'b1;
    repeat (5) tick();
    user_request = 1'b0;
    repeat (12) tick();
    check("long_pulse", {31'b0, user_pending}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
